bus_serial_bridge: RTL and testbench
====================================

# bus_serial_bridge

Parametrised bridge between the CPU's parallel memory port and the chip's 8-bit bidirectional pad bus. It accepts one read or write request through a valid/ready handshake and serialises it as a framed byte sequence: command, address, then write data or read data. It inserts an acknowledge-driven wait phase with optional timeout, and returns a response through a valid/ready handshake. It replaces the fixed 32-bit, fixed-phase pad sequencer, making address/data width and wait behaviour configurable.

## Interface
- ADDR_BYTES, 4, address bytes per frame (1–8)
- DATA_BYTES, 4, data bytes per frame (1–8)
- WAIT_MAX, 15, maximum WAIT cycles before timeout; 0 disables timeout

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge with req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8*ADDR_BYTES  address
- req_wdata  in  8*DATA_BYTES  write data
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  8*DATA_BYTES  read data; 0 for writes and timeouts
- rsp_timeout  out  1  frame ended by timeout
- pad_out  out  8  byte driven onto pads
- pad_oe  out  8  pad output enable, all-ones or all-zeros
- pad_in  in  8  byte sampled from pads
- pad_ack  in  1  external device ready/ack
- frame  out  1  high for the whole frame, CMD through last WAIT/RDATA cycle

## Operation
- States: IDLE, CMD, ADDR, WDATA, WAIT, RDATA, DONE. There is a byte counter and a wait counter of width clog2(WAIT_MAX+1), minimum 1.
- IDLE: req_ready=1, frame=0, pad_oe=0, pad_out=0. On accept, latch write/addr/wdata, clear rdata and timeout, then go to CMD.
- CMD (1 cycle): pad_out = {write, 4'b0000, DATA_BYTES-1 (3 bits)}, pad_oe=FF, frame=1.
- ADDR (ADDR_BYTES cycles): pad_out = address byte k, LSB first, pad_oe=FF.
- After ADDR, a write goes to WDATA and a read goes to WAIT.
- WDATA (DATA_BYTES cycles): pad_out = wdata byte k, LSB first, pad_oe=FF. Then go to WAIT.
- WAIT: pad_oe=0, pad_out=0, frame=1. pad_ack is sampled each edge.
  - ack=1: a read goes to RDATA, a write goes to DONE.
  - Otherwise the wait counter increments. When WAIT_MAX≠0 and the counter reaches WAIT_MAX, set timeout=1 and go to DONE, with rdata left at 0.
- Minimum WAIT is 1 cycle; this is the bus turnaround.
- RDATA (DATA_BYTES cycles): pad_oe=0. Each edge stores pad_in into rdata byte k, LSB first. Then go to DONE.
- DONE: frame=0, pad_oe=0, rsp_valid=1. rsp_rdata and rsp_timeout are stable. On rsp_ready go to IDLE.
- Back-to-back frames always have at least one IDLE cycle between them. req_valid during DONE is not accepted.
- Byte counter resets to 0 on each state entry. State, counters and latched request are registers.
- pad_out, pad_oe, frame, req_ready and rsp_valid decode from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset (asynchronous, any state, including mid-frame): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, pad_out=0, pad_oe=0, frame=0, all counters 0. There is no partial response after reset.
- Write frame: 1 + ADDR_BYTES + DATA_BYTES drive cycles, then W WAIT cycles (W≥1), then DONE.
- Read frame: 1 + ADDR_BYTES drive cycles, then W WAIT cycles, then DATA_BYTES sample cycles, then DONE.
- Default write with ack already high: accept edge → CMD at cycle 1 → ADDR 2–5 → WDATA 6–9 → WAIT 10 → rsp_valid from cycle 11.
- Timeout: exactly WAIT_MAX WAIT cycles, then DONE.
- If ack arrives on the same edge the counter would reach WAIT_MAX, ack wins and timeout=0.
- WAIT_MAX=0: WAIT persists indefinitely until ack.
- pad_ack outside WAIT is ignored.
- pad_in is sampled only in RDATA.

## Test plan
- Reset values, then a default write of addr 0xA0B0C0D0, data 0x12345678, with ack held high.
  - Required: pad_out sequence 83,D0,C0,B0,A0,78,56,34,12 with pad_oe=FF; one WAIT cycle with pad_oe=00; rsp_valid at cycle 11 with timeout=0 and rdata=0.
- Read of 0x00000010; device holds ack low for 3 WAIT cycles, then drives 0xEF,0xBE,0xAD,0xDE.
  - Required: cmd byte 03; 4 WAIT cycles total; rsp_rdata=0xDEADBEEF.
- Read with ack never asserted, WAIT_MAX=15.
  - Required: exactly 15 WAIT cycles, then rsp_timeout=1, rsp_rdata=0; no RDATA cycles.
- rsp_ready held low for 5 cycles in DONE, with req_valid held high throughout.
  - Required: rsp_valid and data stable for all 5 cycles; req_ready=0 until one cycle after the rsp_ready handshake.
- Assert rst during ADDR byte 2 and during RDATA byte 1.
  - Required: outputs return to reset values immediately (before next edge); next request runs a complete clean frame.
- ADDR_BYTES=2, DATA_BYTES=1, write of addr 0x1234, data 0x5A.
  - Required: pad_out sequence 80,34,12,5A, then WAIT and DONE.

Source files
------------

// File: rtl/bus_serial_bridge.sv
// Bridge from a parallel request/response port to an 8-bit framed pad bus:
// CMD, ADDR bytes, optional WDATA bytes, ack-driven WAIT, optional RDATA bytes.
module bus_serial_bridge #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_timeout,
  output logic [7:0]              pad_out,
  output logic [7:0]              pad_oe,
  input  logic [7:0]              pad_in,
  input  logic                    pad_ack,
  output logic                    frame
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int WCW  = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam logic [2:0]     DLEN      = 3'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WAIT, S_RDATA, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BCW-1:0]  r_byte;
  logic [WCW-1:0]  r_wait;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_timeout;

  logic            w_accept;
  logic            w_byte_run;
  logic            w_wait_run;
  logic            w_wait_expire;
  logic [7:0]      w_addr_byte;
  logic [7:0]      w_wdata_byte;

  assign w_accept      = (r_state == S_IDLE) && req_valid;
  assign w_byte_run    = (w_state_next == r_state) &&
                         ((r_state == S_ADDR) || (r_state == S_WDATA) || (r_state == S_RDATA));
  assign w_wait_run    = (r_state == S_WAIT) && (w_state_next == S_WAIT);
  // A zero WAIT_MAX never expires, so WAIT only ends on ack.
  assign w_wait_expire = (WAIT_MAX != 0) && (r_wait == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_CMD;
      S_CMD:   w_state_next = S_ADDR;
      S_ADDR:  if (r_byte == ADDR_LAST) w_state_next = r_write ? S_WDATA : S_WAIT;
      S_WDATA: if (r_byte == DATA_LAST) w_state_next = S_WAIT;
      S_WAIT: begin
        if (pad_ack) begin
          w_state_next = r_write ? S_DONE : S_RDATA;
        end else if (w_wait_expire) begin
          w_state_next = S_DONE;
        end
      end
      S_RDATA: if (r_byte == DATA_LAST) w_state_next = S_DONE;
      S_DONE:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_byte = '0;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (r_byte == BCW'(k)) w_addr_byte = r_addr[8*k +: 8];
    end
  end

  always_comb begin
    w_wdata_byte = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (r_byte == BCW'(k)) w_wdata_byte = r_wdata[8*k +: 8];
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    frame     = 1'b0;
    pad_oe    = 8'h00;
    pad_out   = 8'h00;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
      S_CMD: begin
        frame   = 1'b1;
        pad_oe  = 8'hFF;
        pad_out = {r_write, 4'b0000, DLEN};
      end
      S_ADDR: begin
        frame   = 1'b1;
        pad_oe  = 8'hFF;
        pad_out = w_addr_byte;
      end
      S_WDATA: begin
        frame   = 1'b1;
        pad_oe  = 8'hFF;
        pad_out = w_wdata_byte;
      end
      S_WAIT, S_RDATA: frame = 1'b1;
      S_DONE:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte    <= '0;
      r_wait    <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_byte <= w_byte_run ? r_byte + BCW'(1) : '0;
      r_wait <= w_wait_run ? r_wait + WCW'(1) : '0;
      if (w_accept) begin
        r_write   <= req_write;
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        r_rdata   <= '0;
        r_timeout <= 1'b0;
      end
      if (r_state == S_RDATA) begin
        for (int k = 0; k < DATA_BYTES; k++) begin
          if (r_byte == BCW'(k)) r_rdata[8*k +: 8] <= pad_in;
        end
      end
      // Ack on the expiring edge takes priority over the timeout.
      if ((r_state == S_WAIT) && !pad_ack && w_wait_expire) r_timeout <= 1'b1;
    end
  end

  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_bus_serial_bridge.sv
// Bench for bus_serial_bridge: per-cycle comparison against a frame model built
// from the framing rules, plus literal pad-byte sequences and response values.
`timescale 1ns/1ps
module tb_bus_serial_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid, req_write, rsp_ready, pad_ack;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  pad_in;

  logic        a_req_ready, a_rsp_valid, a_rsp_timeout, a_frame;
  logic [31:0] a_rsp_rdata;
  logic [7:0]  a_pad_out, a_pad_oe;
  logic        b_req_ready, b_rsp_valid, b_rsp_timeout, b_frame;
  logic [7:0]  b_rsp_rdata;
  logic [7:0]  b_pad_out, b_pad_oe;

  bus_serial_bridge dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_timeout(a_rsp_timeout), .pad_out(a_pad_out), .pad_oe(a_pad_oe),
    .pad_in(pad_in), .pad_ack(pad_ack), .frame(a_frame)
  );

  bus_serial_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .WAIT_MAX(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr[15:0]), .req_wdata(req_wdata[7:0]),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_timeout(b_rsp_timeout), .pad_out(b_pad_out), .pad_oe(b_pad_oe),
    .pad_in(pad_in), .pad_ack(pad_ack), .frame(b_frame)
  );

  logic [7:0]  m_pad_out, m_pad_oe;
  logic        m_frame, m_req_ready, m_rsp_valid, m_rsp_timeout;
  logic [63:0] m_rsp_rdata;

  always_comb begin
    m_pad_out = a_pad_out; m_pad_oe = a_pad_oe; m_frame = a_frame;
    m_req_ready = a_req_ready; m_rsp_valid = a_rsp_valid; m_rsp_timeout = a_rsp_timeout;
    m_rsp_rdata = {32'd0, a_rsp_rdata};
    if (sel) begin
      m_pad_out = b_pad_out; m_pad_oe = b_pad_oe; m_frame = b_frame;
      m_req_ready = b_req_ready; m_rsp_valid = b_rsp_valid; m_rsp_timeout = b_rsp_timeout;
      m_rsp_rdata = {56'd0, b_rsp_rdata};
    end
  end

  typedef struct packed {
    logic [7:0]  po;
    logic [7:0]  oe;
    logic        fr;
    logic        rr;
    logic        rv;
    logic        cr;
    logic [63:0] rd;
    logic        to;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic       ack;
    logic [7:0] pin;
    logic       rr;
  } stim_t;

  exp_t  eq[$];
  stim_t sq[$];
  exp_t  exp_cur;
  logic  exp_en = 1'b0;
  int    cur_idx = -1;
  int    cfg_ab = 4, cfg_db = 4, cfg_wmax = 15;

  int    checks = 0;
  int    errors = 0;

  logic [7:0]  drv_log[$];
  logic [7:0]  lit[$];
  int          n_quiet;
  int          rsp_first;
  logic [63:0] rsp_rd_cap;
  logic        rsp_to_cap;
  logic        fr_write;
  logic [31:0] fr_addr, fr_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] po, input logic [7:0] oe, input logic fr,
                              input logic rr, input logic rv, input logic cr,
                              input logic [63:0] rd, input logic to);
    exp_t e;
    e.po = po; e.oe = oe; e.fr = fr; e.rr = rr; e.rv = rv; e.cr = cr; e.rd = rd; e.to = to;
    return e;
  endfunction

  function automatic stim_t ms(input logic v, input logic ack, input logic [7:0] pin, input logic rr);
    stim_t s;
    s.v = v; s.ack = ack; s.pin = pin; s.rr = rr;
    return s;
  endfunction

  // Expected cycle-by-cycle picture of one transaction, starting with the IDLE cycle that
  // offers the request. ack_low = WAIT cycles with ack low before it rises (-1: never).
  task automatic build_frame(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [63:0] rsrc, input int ack_low, input int hold,
                             input logic valid_in_done);
    int          nw;
    logic        timed;
    logic [63:0] rd_exp;
    exp_t        quiet;
    eq.delete(); sq.delete();
    fr_write = w; fr_addr = addr; fr_wdata = wdata;
    timed = (cfg_wmax != 0) && ((ack_low < 0) || (ack_low >= cfg_wmax));
    nw = timed ? cfg_wmax : ack_low + 1;
    rd_exp = 64'd0;
    if (!w && !timed) begin
      for (int k = 0; k < cfg_db; k++) rd_exp[8*k +: 8] = rsrc[8*k +: 8];
    end
    quiet = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    eq.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
    sq.push_back(ms(1'b1, 1'b1, 8'hA5, 1'b0));
    eq.push_back(mk(8'((w ? 128 : 0) + cfg_db - 1), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
    sq.push_back(ms(1'b0, 1'b1, 8'hA5, 1'b0));
    for (int k = 0; k < cfg_ab; k++) begin
      eq.push_back(mk(8'(addr >> (8 * k)), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
      sq.push_back(ms(1'b0, 1'b1, 8'hA5, 1'b0));
    end
    if (w) begin
      for (int k = 0; k < cfg_db; k++) begin
        eq.push_back(mk(8'(wdata >> (8 * k)), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
        sq.push_back(ms(1'b0, 1'b1, 8'hA5, 1'b0));
      end
    end
    for (int i = 0; i < nw; i++) begin
      eq.push_back(quiet);
      sq.push_back(ms(1'b0, (ack_low >= 0) && (i >= ack_low), 8'hA5, 1'b0));
    end
    if (!w && !timed) begin
      for (int k = 0; k < cfg_db; k++) begin
        eq.push_back(quiet);
        sq.push_back(ms(1'b0, 1'b1, 8'(rsrc >> (8 * k)), 1'b0));
      end
    end
    for (int i = 0; i <= hold; i++) begin
      eq.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, rd_exp, timed));
      sq.push_back(ms(valid_in_done, 1'b1, 8'hA5, i == hold));
    end
  endtask

  task automatic run_frame(input int upto);
    int n;
    n = (upto < 0) ? eq.size() : upto;
    drv_log.delete(); n_quiet = 0; rsp_first = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_idx = i; exp_cur = eq[i]; exp_en = 1'b1;
      req_valid = sq[i].v; pad_ack = sq[i].ack; pad_in = sq[i].pin; rsp_ready = sq[i].rr;
      req_write = fr_write; req_addr = fr_addr; req_wdata = fr_wdata;
    end
    @(negedge clk); #1;
    exp_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_idx = -1; exp_en = 1'b1;
      exp_cur = mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
      req_valid = 1'b0; rsp_ready = 1'b0; pad_ack = 1'b0;
    end
    @(negedge clk); #1;
    exp_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},   64'(m_req_ready), 64'd1);
    check({tag, ".rsp_valid"},   64'(m_rsp_valid), 64'd0);
    check({tag, ".rsp_rdata"},   m_rsp_rdata, 64'd0);
    check({tag, ".rsp_timeout"}, 64'(m_rsp_timeout), 64'd0);
    check({tag, ".pad_out"},     64'(m_pad_out), 64'd0);
    check({tag, ".pad_oe"},      64'(m_pad_oe), 64'd0);
    check({tag, ".frame"},       64'(m_frame), 64'd0);
  endtask

  task automatic reset_mid(input int ncyc, input string tag);
    run_frame(ncyc);
    rst = 1'b1;
    #1;
    check_reset_outputs({tag, ".async"});
    @(posedge clk); #1;
    check_reset_outputs({tag, ".held"});
    rst = 1'b0; req_valid = 1'b0;
    $display("reset %s after %0d cycles of frame", tag, ncyc);
  endtask

  task automatic check_log(input string tag, input logic [7:0] seq[$]);
    check({tag, ".nbytes"}, 64'(drv_log.size()), 64'(seq.size()));
    for (int k = 0; k < seq.size() && k < drv_log.size(); k++) begin
      check($sformatf("%s.byte%0d", tag, k), 64'(drv_log[k]), 64'(seq[k]));
    end
  endtask

  task automatic report(input string tag);
    $display("frame %s: write=%0b addr=0x%h first_rsp_cycle=%0d quiet=%0d rdata=0x%h timeout=%0b",
             tag, fr_write, fr_addr, rsp_first, n_quiet, rsp_rd_cap, rsp_to_cap);
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      check("pad_out",   64'(m_pad_out),   64'(exp_cur.po));
      check("pad_oe",    64'(m_pad_oe),    64'(exp_cur.oe));
      check("frame",     64'(m_frame),     64'(exp_cur.fr));
      check("req_ready", 64'(m_req_ready), 64'(exp_cur.rr));
      check("rsp_valid", 64'(m_rsp_valid), 64'(exp_cur.rv));
      if (exp_cur.cr) begin
        check("rsp_rdata",   m_rsp_rdata,         exp_cur.rd);
        check("rsp_timeout", 64'(m_rsp_timeout),  64'(exp_cur.to));
      end
      if (m_pad_oe == 8'hFF) drv_log.push_back(m_pad_out);
      if (m_frame && (m_pad_oe == 8'h00)) n_quiet++;
      if (m_rsp_valid && (rsp_first < 0)) begin
        rsp_first = cur_idx; rsp_rd_cap = m_rsp_rdata; rsp_to_cap = m_rsp_timeout;
      end
    end
  end

  initial begin
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pad_in = 8'h00; pad_ack = 1'b0;
    rsp_rd_cap = '0; rsp_to_cap = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rst = 1'b0;
    idle_cycles(2);

    // Default write, ack held high the whole time.
    build_frame(1'b1, 32'hA0B0C0D0, 32'h12345678, 64'd0, 0, 0, 1'b0);
    run_frame(-1);
    lit = '{8'h83, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h78, 8'h56, 8'h34, 8'h12};
    check_log("wr_default", lit);
    check("wr_default.quiet", 64'(n_quiet), 64'd1);
    check("wr_default.rsp_cycle", 64'(rsp_first), 64'd11);
    check("wr_default.rdata", rsp_rd_cap, 64'd0);
    report("wr_default");

    // Read with three ack-low WAIT cycles.
    build_frame(1'b0, 32'h00000010, 32'd0, 64'hDEADBEEF, 3, 0, 1'b0);
    run_frame(-1);
    lit = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
    check_log("rd_wait3", lit);
    check("rd_wait3.quiet", 64'(n_quiet), 64'd8);
    check("rd_wait3.rsp_cycle", 64'(rsp_first), 64'd14);
    check("rd_wait3.rdata", rsp_rd_cap, 64'hDEADBEEF);
    report("rd_wait3");

    // Read that never sees ack: timeout after exactly 15 WAIT cycles.
    build_frame(1'b0, 32'h00000020, 32'd0, 64'h11111111, -1, 0, 1'b0);
    run_frame(-1);
    check("rd_timeout.quiet", 64'(n_quiet), 64'd15);
    check("rd_timeout.rsp_cycle", 64'(rsp_first), 64'd21);
    check("rd_timeout.timeout", 64'(rsp_to_cap), 64'd1);
    check("rd_timeout.rdata", rsp_rd_cap, 64'd0);
    report("rd_timeout");

    // Ack on the very cycle the timeout would fire: ack wins.
    build_frame(1'b0, 32'h00000030, 32'd0, 64'hCAFEF00D, 14, 0, 1'b0);
    run_frame(-1);
    check("rd_lastack.quiet", 64'(n_quiet), 64'd19);
    check("rd_lastack.timeout", 64'(rsp_to_cap), 64'd0);
    check("rd_lastack.rdata", rsp_rd_cap, 64'hCAFEF00D);
    report("rd_lastack");

    // Response held 5 cycles with req_valid high, then the next request goes straight in.
    build_frame(1'b0, 32'h00000055, 32'd0, 64'h01020304, 1, 5, 1'b1);
    run_frame(-1);
    check("rd_hold.rsp_cycle", 64'(rsp_first), 64'd12);
    check("rd_hold.rdata", rsp_rd_cap, 64'h01020304);
    report("rd_hold");
    build_frame(1'b1, 32'h0BAD0000, 32'h11223344, 64'd0, 2, 0, 1'b0);
    run_frame(-1);
    check("wr_b2b.rsp_cycle", 64'(rsp_first), 64'd13);
    report("wr_b2b");
    idle_cycles(2);

    // Reset during ADDR byte 2, then a clean write.
    build_frame(1'b1, 32'hFFEEDDCC, 32'h55555555, 64'd0, 0, 0, 1'b0);
    reset_mid(5, "rst_addr");
    build_frame(1'b1, 32'h01020304, 32'hAABBCCDD, 64'd0, 0, 0, 1'b0);
    run_frame(-1);
    lit = '{8'h83, 8'h04, 8'h03, 8'h02, 8'h01, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    check_log("wr_after_rst", lit);
    report("wr_after_rst");

    // Reset during RDATA byte 1, then a clean read.
    build_frame(1'b0, 32'h00000040, 32'd0, 64'h99887766, 0, 0, 1'b0);
    reset_mid(9, "rst_rdata");
    build_frame(1'b0, 32'h00000044, 32'd0, 64'h13579BDF, 2, 0, 1'b0);
    run_frame(-1);
    check("rd_after_rst.rdata", rsp_rd_cap, 64'h13579BDF);
    check("rd_after_rst.quiet", 64'(n_quiet), 64'd7);
    report("rd_after_rst");

    // Narrow instance: 2 address bytes, 1 data byte, no timeout.
    sel = 1'b1; cfg_ab = 2; cfg_db = 1; cfg_wmax = 0;
    idle_cycles(1);
    build_frame(1'b1, 32'h00001234, 32'h0000005A, 64'd0, 20, 0, 1'b0);
    run_frame(-1);
    lit = '{8'h80, 8'h34, 8'h12, 8'h5A};
    check_log("narrow_wr", lit);
    check("narrow_wr.quiet", 64'(n_quiet), 64'd21);
    check("narrow_wr.rsp_cycle", 64'(rsp_first), 64'd26);
    check("narrow_wr.timeout", 64'(rsp_to_cap), 64'd0);
    report("narrow_wr");
    build_frame(1'b0, 32'h0000BEEF, 32'd0, 64'h77, 0, 0, 1'b0);
    run_frame(-1);
    lit = '{8'h00, 8'hEF, 8'hBE};
    check_log("narrow_rd", lit);
    check("narrow_rd.rdata", rsp_rd_cap, 64'h77);
    report("narrow_rd");
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
